// File: rtl/sensor_scan_sequencer_pkg.sv
// Shared definitions for the greenhouse sensor scan sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sensor_scan_sequencer_pkg;

    localparam int DATA_W_DEF = 8;

    // Sensor index on the shared read port
    localparam logic [1:0] SENS_TEMP  = 2'd0;
    localparam logic [1:0] SENS_HUMID = 2'd1;
    localparam logic [1:0] SENS_LIGHT = 2'd2;
    localparam logic [1:0] SENS_MOIST = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_GAP     = 3'd2,
        ST_PUBLISH = 3'd3,
        ST_WAIT    = 3'd4
    } state_t;

endpackage

// File: rtl/sensor_req_timer.sv
// Loadable down-counter; expired is high while the count sits at 1 (the last counted cycle).
// Latency: load takes effect on the next clock; expired is combinational from the count.
// Backpressure: none; load has priority over dec, and the count holds at zero.
module sensor_req_timer
    import sensor_scan_sequencer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: a load overrides the decrement; never wraps below zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/sensor_scan_sequencer.sv
// Periodic scan of four sensors over one req/ack port; publishes all four values together.
// Latency: req 1 cycle after enable seen in IDLE, 2 cycles per sensor with immediate ack, snapshot_valid on cycle 9.
// Backpressure: each read is bounded by TIMEOUT_CYC; SENSOR_RETRY_EN adds one retry per timed-out sensor.
module sensor_scan_sequencer
    import sensor_scan_sequencer_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 1000,
    parameter int TIMEOUT_CYC   = 255,
    parameter int DATA_W        = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              req,
    output logic [1:0]        sel,
    input  logic              ack,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] temperature,
    output logic [DATA_W-1:0] humidity,
    output logic [DATA_W-1:0] light_level,
    output logic [DATA_W-1:0] moisture,
    output logic              snapshot_valid,
    output logic [3:0]        timeout_err,
    output logic              busy,
    output logic [7:0]        scan_count
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int SP_W = $clog2(SAMPLE_PERIOD + 1);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYC);
    localparam logic [SP_W-1:0] SP_LOAD = SP_W'(SAMPLE_PERIOD);

    state_t                  state_q, state_d;
    logic                    req_q, req_d;
    logic [1:0]              sel_q, sel_d;
    logic                    busy_q, busy_d;
    logic [3:0][DATA_W-1:0]  shadow_q, shadow_d;
    logic [3:0]              err_pend_q, err_pend_d;
    logic [3:0][DATA_W-1:0]  snap_q, snap_d;
    logic [3:0]              err_q, err_d;
    logic                    valid_q, valid_d;
    logic [7:0]              count_q, count_d;
`ifdef SENSOR_RETRY_EN
    logic                    retry_q, retry_d;
`endif

    logic            to_load;
    logic [TO_W-1:0] to_val;
    logic            to_expired;
    logic            per_load;
    logic [SP_W-1:0] per_val;
    logic            per_expired;

    // Per-read timeout: loaded on entry to REQ, counts only while req is high
    sensor_req_timer #(.CNT_W(TO_W)) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (to_load),
        .load_val (to_val),
        .dec      (state_q == ST_REQ),
        .expired  (to_expired)
    );

    // Scan interval: loaded on entry to WAIT, counts only in WAIT
    sensor_req_timer #(.CNT_W(SP_W)) u_period (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (per_load),
        .load_val (per_val),
        .dec      (state_q == ST_WAIT),
        .expired  (per_expired)
    );

    // Next-state and registered-output decode of the scan FSM
    always_comb begin
        state_d    = state_q;
        req_d      = 1'b0;
        sel_d      = sel_q;
        busy_d     = busy_q;
        shadow_d   = shadow_q;
        err_pend_d = err_pend_q;
        snap_d     = snap_q;
        err_d      = err_q;
        valid_d    = 1'b0;
        count_d    = count_q;
        to_load    = 1'b0;
        to_val     = '0;
        per_load   = 1'b0;
        per_val    = '0;
`ifdef SENSOR_RETRY_EN
        retry_d    = retry_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    sel_d   = SENS_TEMP;
                    busy_d  = 1'b1;
                    to_load = 1'b1;
                    to_val  = TO_LOAD;
                end
            end
            ST_REQ: begin
                // ack beats an expiring timeout on the same cycle
                if (ack) begin
                    shadow_d[sel_q]   = rdata;
                    err_pend_d[sel_q] = 1'b0;
                    state_d           = ST_GAP;
`ifdef SENSOR_RETRY_EN
                    retry_d           = 1'b0;
`endif
                end else if (to_expired) begin
                    state_d = ST_GAP;
`ifdef SENSOR_RETRY_EN
                    if (!retry_q) begin
                        retry_d = 1'b1;
                    end else begin
                        retry_d           = 1'b0;
                        err_pend_d[sel_q] = 1'b1;
                    end
`else
                    err_pend_d[sel_q] = 1'b1;
`endif
                end else begin
                    req_d = 1'b1;
                end
            end
            ST_GAP: begin
                to_load = 1'b1;
`ifdef SENSOR_RETRY_EN
                if (retry_q) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    to_val  = TO_LOAD;
                end else
`endif
                if (sel_q != SENS_MOIST) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    sel_d   = sel_q + 2'd1;
                    to_val  = TO_LOAD;
                end else begin
                    // Whole snapshot becomes visible on the edge entering PUBLISH
                    state_d = ST_PUBLISH;
                    sel_d   = SENS_TEMP;
                    snap_d  = shadow_q;
                    err_d   = err_pend_q;
                    valid_d = 1'b1;
                    count_d = count_q + 8'd1;
                end
            end
            ST_PUBLISH: begin
                busy_d = 1'b0;
                if (enable) begin
                    state_d  = ST_WAIT;
                    per_load = 1'b1;
                    per_val  = SP_LOAD;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_d  = ST_IDLE;
                    per_load = 1'b1;
                end else if (per_expired) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    sel_d   = SENS_TEMP;
                    busy_d  = 1'b1;
                    to_load = 1'b1;
                    to_val  = TO_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // FSM state and all registered outputs; reset discards any partial scan
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            sel_q      <= SENS_TEMP;
            busy_q     <= 1'b0;
            shadow_q   <= '0;
            err_pend_q <= '0;
            snap_q     <= '0;
            err_q      <= '0;
            valid_q    <= 1'b0;
            count_q    <= '0;
`ifdef SENSOR_RETRY_EN
            retry_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
            shadow_q   <= shadow_d;
            err_pend_q <= err_pend_d;
            snap_q     <= snap_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
`ifdef SENSOR_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    assign req            = req_q;
    assign sel            = sel_q;
    assign busy           = busy_q;
    assign temperature    = snap_q[SENS_TEMP];
    assign humidity       = snap_q[SENS_HUMID];
    assign light_level    = snap_q[SENS_LIGHT];
    assign moisture       = snap_q[SENS_MOIST];
    assign timeout_err    = err_q;
    assign snapshot_valid = valid_q;
    assign scan_count     = count_q;

endmodule

// File: tb/tb_sensor_scan_sequencer.sv
// Self-checking bench for sensor_scan_sequencer with a scan-level reference model.
// Latency: n/a.
// Backpressure: the sensor responder acks per a per-sensor, per-attempt delay plan.
module tb_sensor_scan_sequencer;

    localparam int TO = 4;
    localparam int SP = 10;
    localparam int DW = 8;
`ifdef SENSOR_RETRY_EN
    localparam int RETRY = 1;
`else
    localparam int RETRY = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          req;
    logic [1:0]    sel;
    logic          ack = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic [DW-1:0] temperature, humidity, light_level, moisture;
    logic          snapshot_valid;
    logic [3:0]    timeout_err;
    logic          busy;
    logic [7:0]    scan_count;

    sensor_scan_sequencer #(
        .SAMPLE_PERIOD (SP),
        .TIMEOUT_CYC   (TO),
        .DATA_W        (DW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .req            (req),
        .sel            (sel),
        .ack            (ack),
        .rdata          (rdata),
        .temperature    (temperature),
        .humidity       (humidity),
        .light_level    (light_level),
        .moisture       (moisture),
        .snapshot_valid (snapshot_valid),
        .timeout_err    (timeout_err),
        .busy           (busy),
        .scan_count     (scan_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus plan: ack on the Nth req-high cycle of an attempt (0 or >TO means never)
    int         plan_dly [4][2];
    logic [7:0] plan_dat [4];

    // Responder observations
    int         pulse_q[$];
    int         last_start_cyc = 0;
    int         run_len = 0;
    int         cur_sel = 0;
    int         cur_att = 0;
    int         last_pulse_sel = 3;
    int         att_cnt [4] = '{0, 0, 0, 0};

    // Sensor side: acks per plan while req is high, random noise on ack/rdata otherwise
    always @(negedge clk) begin
        if (req === 1'b1) begin
            if (run_len == 0) begin
                cur_sel = int'(sel);
                if (cur_sel == 0 && last_pulse_sel != 0) begin
                    last_start_cyc = cyc;
                    for (int i = 0; i < 4; i++) att_cnt[i] = 0;
                end
                cur_att = (att_cnt[cur_sel] > 0) ? 1 : 0;
                att_cnt[cur_sel] = att_cnt[cur_sel] + 1;
            end
            run_len = run_len + 1;
            if (plan_dly[cur_sel][cur_att] == run_len) begin
                ack   = 1'b1;
                rdata = plan_dat[cur_sel];
            end else begin
                ack   = 1'b0;
                rdata = 8'($urandom);
            end
        end else begin
            if (run_len != 0) begin
                pulse_q.push_back(run_len);
                last_pulse_sel = cur_sel;
                run_len = 0;
            end
            ack   = 1'($urandom_range(0, 1));
            rdata = 8'($urandom);
        end
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          mon_en  = 1'b0;
    logic [63:0] prev_vec = '0;

    // Reference model state
    logic [7:0] exp_snap [4] = '{8'h0, 8'h0, 8'h0, 8'h0};
    logic [3:0] exp_err = '0;
    logic [7:0] exp_cnt = '0;
    int         exp_len = 0;
    int         exp_pulses[$];
    int         prev_valid_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] out_vec();
        return {20'd0, temperature, humidity, light_level, moisture, timeout_err, scan_count};
    endfunction

    // Advance to the next falling edge; published outputs may only move with snapshot_valid
    task automatic tick();
        @(negedge clk);
        if (mon_en && snapshot_valid !== 1'b1) chk("outputs_stable", out_vec(), prev_vec);
        prev_vec = out_vec();
    endtask

    // Expected result of one scan from the plan, computed sensor by sensor
    task automatic model_scan();
        exp_len = 0;
        exp_pulses.delete();
        for (int s = 0; s < 4; s++) begin
            bit got = 1'b0;
            for (int a = 0; a < 1 + RETRY; a++) begin
                if (!got) begin
                    if (plan_dly[s][a] >= 1 && plan_dly[s][a] <= TO) begin
                        got = 1'b1;
                        exp_len += plan_dly[s][a] + 1;
                        exp_pulses.push_back(plan_dly[s][a]);
                    end else begin
                        exp_len += TO + 1;
                        exp_pulses.push_back(TO);
                    end
                end
            end
            if (got) exp_snap[s] = plan_dat[s];
            exp_err[s] = !got;
        end
        exp_cnt = exp_cnt + 8'd1;
    endtask

    task automatic set_plan(input int d0, input int d1, input int d2, input int d3, input int r);
        plan_dly[0][0] = d0; plan_dly[1][0] = d1; plan_dly[2][0] = d2; plan_dly[3][0] = d3;
        for (int s = 0; s < 4; s++) plan_dly[s][1] = r;
    endtask

    task automatic run_scan(input string tag, input bit chk_period, input bit drop_en);
        int k;
        int base;
        base = pulse_q.size();
        model_scan();
        k = 0;
        while (snapshot_valid !== 1'b1 && k < 3000) begin
            tick();
            if (drop_en && req === 1'b1 && sel === 2'd1) enable = 1'b0;
            k++;
        end
        chk({tag, "_valid_seen"}, 64'(k < 3000), 64'd1);
        chk({tag, "_latency"}, 64'(cyc - last_start_cyc), 64'(exp_len));
        if (chk_period) chk({tag, "_period"}, 64'(cyc - prev_valid_cyc), 64'(1 + SP + exp_len));
        prev_valid_cyc = cyc;
        chk({tag, "_temp"},  64'(temperature), 64'(exp_snap[0]));
        chk({tag, "_humid"}, 64'(humidity),    64'(exp_snap[1]));
        chk({tag, "_light"}, 64'(light_level), 64'(exp_snap[2]));
        chk({tag, "_moist"}, 64'(moisture),    64'(exp_snap[3]));
        chk({tag, "_err"},   64'(timeout_err), 64'(exp_err));
        chk({tag, "_count"}, 64'(scan_count),  64'(exp_cnt));
        chk({tag, "_npulse"}, 64'(pulse_q.size() - base), 64'(exp_pulses.size()));
        for (int i = 0; i < exp_pulses.size(); i++) begin
            if (base + i < pulse_q.size())
                chk({tag, "_req_len"}, 64'(pulse_q[base + i]), 64'(exp_pulses[i]));
        end
        tick();
        chk({tag, "_valid_1cyc"}, 64'(snapshot_valid), 64'd0);
    endtask

    initial begin
        int k;
        int nreq;
        int nval;
        for (int s = 0; s < 4; s++) begin
            plan_dly[s][0] = 1; plan_dly[s][1] = 1; plan_dat[s] = 8'h00;
        end
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_req",   64'(req),            64'd0);
        chk("rst_sel",   64'(sel),            64'd0);
        chk("rst_valid", 64'(snapshot_valid), 64'd0);
        chk("rst_busy",  64'(busy),           64'd0);
        chk("rst_outs",  out_vec(),           64'd0);
        mon_en = 1'b1;

        // Immediate acks on every sensor
        set_plan(1, 1, 1, 1, 1);
        plan_dat[0] = 8'h15; plan_dat[1] = 8'h3C; plan_dat[2] = 8'h32; plan_dat[3] = 8'h46;
        enable = 1'b1;
        run_scan("imm", 1'b0, 1'b0);
        chk("imm_busy_wait", 64'(busy), 64'd0);

        // Light never answers: keeps old value and flags it
        set_plan(1, 2, 0, 1, 0);
        plan_dat[0] = 8'h01; plan_dat[1] = 8'h02; plan_dat[2] = 8'hEE; plan_dat[3] = 8'h04;
        run_scan("to_light", 1'b1, 1'b0);

        // Ack on the final allowed req cycle is still accepted
        set_plan(TO, 1, 3, TO, 0);
        plan_dat[0] = 8'hA5; plan_dat[1] = 8'h5A; plan_dat[2] = 8'h77; plan_dat[3] = 8'hC3;
        run_scan("ack_last", 1'b1, 1'b0);

        // Humidity silent on first attempt, answers on a second attempt if one is made
        set_plan(1, 0, 1, 1, 0);
        plan_dly[1][1] = 3;
        plan_dat[0] = 8'h11; plan_dat[1] = 8'h22; plan_dat[2] = 8'h33; plan_dat[3] = 8'h44;
        run_scan("retry", 1'b1, 1'b0);

        // Random scans until the scan counter has wrapped past 255
        for (int n = 0; n < 254; n++) begin
            for (int s = 0; s < 4; s++) begin
                plan_dly[s][0] = $urandom_range(0, TO + 1);
                plan_dly[s][1] = $urandom_range(0, TO + 1);
                plan_dat[s]    = 8'($urandom);
            end
            run_scan("rand", 1'b1, 1'b0);
        end
        chk("wrap_count", 64'(scan_count), 64'd2);

        // enable drops mid-scan: finish, publish once, then stay idle
        set_plan(2, 2, 2, 2, 2);
        for (int s = 0; s < 4; s++) plan_dat[s] = 8'($urandom);
        run_scan("drop_en", 1'b1, 1'b1);
        chk("drop_busy", 64'(busy), 64'd0);
        nreq = 0;
        nval = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (req !== 1'b0) nreq++;
            if (snapshot_valid !== 1'b0) nval++;
        end
        chk("drop_no_req",   64'(nreq), 64'd0);
        chk("drop_no_valid", 64'(nval), 64'd0);

        // Reset in the middle of the light read discards the scan
        set_plan(1, 1, 0, 1, 0);
        enable = 1'b1;
        k = 0;
        while (!(req === 1'b1 && sel === 2'd2) && k < 200) begin
            tick();
            k++;
        end
        chk("rst_mid_reach_sel2", 64'(k < 200), 64'd1);
        tick();
        mon_en = 1'b0;
        rst_n  = 1'b0;
        tick();
        chk("rst_mid_req",   64'(req),  64'd0);
        chk("rst_mid_busy",  64'(busy), 64'd0);
        chk("rst_mid_sel",   64'(sel),  64'd0);
        chk("rst_mid_outs",  out_vec(), 64'd0);
        nval = (snapshot_valid !== 1'b0) ? 1 : 0;
        enable = 1'b0;
        repeat (3) begin
            tick();
            if (snapshot_valid !== 1'b0) nval++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            if (snapshot_valid !== 1'b0) nval++;
        end
        chk("rst_mid_no_valid", 64'(nval), 64'd0);
        for (int s = 0; s < 4; s++) exp_snap[s] = 8'h00;
        exp_err = '0;
        exp_cnt = '0;
        mon_en  = 1'b1;

        // Fresh scan after reset; humidity needs a second attempt
        set_plan(1, 0, 2, 1, 0);
        plan_dly[1][1] = 2;
        plan_dat[0] = 8'h61; plan_dat[1] = 8'h62; plan_dat[2] = 8'h63; plan_dat[3] = 8'h64;
        enable = 1'b1;
        run_scan("post_rst", 1'b0, 1'b0);
        enable = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
